// File: rtl/marc_ctrl_pkg.sv
// Shared constants for the mARC control unit: one-hot state bit numbering,
// reset state and IR opclass encodings used by the sequencer and output decode.
package marc_ctrl_pkg;

  localparam int STATE_W = 13;
  localparam logic [STATE_W-1:0] STATE_RESET = 13'h0001;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_LOAD_IR    = 4'd1,
    S_DECODE     = 4'd2,
    S_ALU_RR     = 4'd3,
    S_ALU_IMM    = 4'd4,
    S_MEM        = 4'd5,
    S_BR_EVAL    = 4'd6,
    S_BR_UPDATE  = 4'd7,
    S_CALL_LINK  = 4'd8,
    S_WRITEBACK  = 4'd9,
    S_RETURN     = 4'd10,
    S_TRAP_ENTRY = 4'd11,
    S_RETIRE     = 4'd12
  } state_idx_e;

  typedef enum logic [1:0] {
    OPC_ALU_RR  = 2'b00,
    OPC_ALU_IMM = 2'b01,
    OPC_MEM     = 2'b10,
    OPC_CTRL    = 2'b11
  } opclass_e;

  typedef enum logic [1:0] {
    CTL_BRANCH = 2'b00,
    CTL_CALL   = 2'b01,
    CTL_RETURN = 2'b10,
    CTL_TRAP   = 2'b11
  } ctlclass_e;

  function automatic logic [STATE_W-1:0] st_bit(input state_idx_e idx);
    return STATE_W'(1) << idx;
  endfunction

  // Zero and multi-hot vectors both fail; x & (x-1) clears the lowest set bit.
  function automatic logic is_onehot(input logic [STATE_W-1:0] s);
    return (s != '0) && ((s & (s - STATE_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction/status inputs and sequencer outputs of the mARC control sequencer.
interface control_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      ir;
  logic [4:0]       status;
  logic             mem_ready;
  logic             irq;
  logic [12:0]      state;
  logic             irq_ack;
  logic             halted;
  logic             fsm_err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output ir, status, mem_ready, irq,
    input  state, irq_ack, halted, fsm_err, instr_count
  );

  modport slave (
    input  ir, status, mem_ready, irq,
    output state, irq_ack, halted, fsm_err, instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// One-hot fetch/decode/execute/retire sequencer for the mARC control unit,
// with interrupt entry at instruction boundaries and illegal-state recovery.
module control_sequencer
  import marc_ctrl_pkg::*;
#(
  parameter int          CNT_W       = 16,
  parameter logic [15:0] HALT_OPCODE = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  control_sequencer_if.slave bus
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               irq_ack_q, irq_ack_d;
  logic               halted_q, halted_d;
  logic               fsm_err_q, fsm_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic      irq_take;
  opclass_e  opc;
  ctlclass_e ctl;
  logic      unused_bits;

  assign irq_take    = bus.irq & bus.status[4];
  assign opc         = opclass_e'(bus.ir[15:14]);
  assign ctl         = ctlclass_e'(bus.ir[13:12]);
  assign unused_bits = ^{bus.status[3:0], bus.ir[10:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STATE_RESET;
      irq_ack_q <= 1'b0;
      halted_q  <= 1'b0;
      fsm_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      irq_ack_q <= irq_ack_d;
      halted_q  <= halted_d;
      fsm_err_q <= fsm_err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = STATE_RESET;
    irq_ack_d = 1'b0;
    halted_d  = 1'b0;
    fsm_err_d = fsm_err_q;
    cnt_d     = cnt_q;
    if (!is_onehot(state_q)) begin
      fsm_err_d = 1'b1;
    end else begin
      case (1'b1)
        state_q[S_FETCH]:   state_d = bus.mem_ready ? st_bit(S_LOAD_IR) : st_bit(S_FETCH);
        state_q[S_LOAD_IR]: state_d = st_bit(S_DECODE);
        state_q[S_DECODE]: begin
          if (bus.ir == HALT_OPCODE) begin
            // A parked halt is an instruction boundary, so an enabled irq may break it.
            if (irq_take) begin
              state_d   = st_bit(S_TRAP_ENTRY);
              irq_ack_d = 1'b1;
            end else begin
              state_d  = st_bit(S_DECODE);
              halted_d = 1'b1;
            end
          end else begin
            case (opc)
              OPC_ALU_RR:  state_d = st_bit(S_ALU_RR);
              OPC_ALU_IMM: state_d = st_bit(S_ALU_IMM);
              OPC_MEM:     state_d = st_bit(S_MEM);
              default: begin
                case (ctl)
                  CTL_BRANCH: state_d = st_bit(S_BR_EVAL);
                  CTL_CALL:   state_d = st_bit(S_CALL_LINK);
                  CTL_RETURN: state_d = st_bit(S_RETURN);
                  default:    state_d = st_bit(S_TRAP_ENTRY);
                endcase
              end
            endcase
          end
        end
        state_q[S_ALU_RR], state_q[S_ALU_IMM]: state_d = st_bit(S_RETIRE);
        state_q[S_MEM]: begin
          if (!bus.mem_ready)  state_d = st_bit(S_MEM);
          else if (bus.ir[11]) state_d = st_bit(S_RETIRE);
          else                 state_d = st_bit(S_WRITEBACK);
        end
        state_q[S_BR_EVAL]:    state_d = st_bit(S_BR_UPDATE);
        state_q[S_BR_UPDATE]:  state_d = st_bit(S_RETIRE);
        state_q[S_CALL_LINK]:  state_d = st_bit(S_WRITEBACK);
        state_q[S_WRITEBACK]:  state_d = st_bit(S_RETIRE);
        state_q[S_RETURN]:     state_d = st_bit(S_RETIRE);
        state_q[S_TRAP_ENTRY]: state_d = st_bit(S_FETCH);
        state_q[S_RETIRE]: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (irq_take) begin
            state_d   = st_bit(S_TRAP_ENTRY);
            irq_ack_d = 1'b1;
          end else begin
            state_d = st_bit(S_FETCH);
          end
        end
        default: state_d = STATE_RESET;
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.irq_ack     = irq_ack_q;
  assign bus.halted      = halted_q;
  assign bus.fsm_err     = fsm_err_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Cycle-table bench for control_sequencer: each record holds the inputs for one
// cycle and the outputs expected after the following rising edge.
module tb_control_sequencer;

  localparam int CW = 4;

  localparam logic [12:0] E0  = 13'h0001, E1  = 13'h0002, E2  = 13'h0004,
                          E3  = 13'h0008, E4  = 13'h0010, E5  = 13'h0020,
                          E6  = 13'h0040, E7  = 13'h0080, E8  = 13'h0100,
                          E9  = 13'h0200, E10 = 13'h0400, E11 = 13'h0800,
                          E12 = 13'h1000;

  typedef struct packed {
    logic [15:0]   ir;
    logic [4:0]    status;
    logic          irq;
    logic          mr;
    logic [12:0]   e_state;
    logic          e_ack;
    logic          e_halt;
    logic          e_err;
    logic [CW-1:0] e_cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  control_sequencer_if #(.CNT_W(CW)) bus ();

  control_sequencer #(.CNT_W(CW), .HALT_OPCODE(16'hFFFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t          tbl[$];
  vec_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            vidx   = 0;
  logic [CW-1:0] ecnt;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vector %0d): got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] ir, input logic [4:0] st, input logic irq,
                     input logic mr, input logic [12:0] es, input logic ea,
                     input logic eh, input logic ret);
    vec_t v;
    if (ret) ecnt = ecnt + CW'(1);
    v = '{ir: ir, status: st, irq: irq, mr: mr, e_state: es, e_ack: ea,
          e_halt: eh, e_err: 1'b0, e_cnt: ecnt};
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.ir        = v.ir;
    bus.status    = v.status;
    bus.irq       = v.irq;
    bus.mem_ready = v.mr;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    sb.push_back(v);
  endtask

  function automatic vec_t mk(input logic [15:0] ir, input logic mr,
                              input logic [12:0] es, input logic err,
                              input logic [CW-1:0] cnt);
    return '{ir: ir, status: 5'h00, irq: 1'b0, mr: mr, e_state: es, e_ack: 1'b0,
             e_halt: 1'b0, e_err: err, e_cnt: cnt};
  endfunction

  // Scoreboard consumer: one expectation per rising edge while the queue is non-empty.
  always @(posedge clk) begin
    vec_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("state",       vidx, 32'(bus.state),       32'(e.e_state));
      chk("irq_ack",     vidx, 32'(bus.irq_ack),     32'(e.e_ack));
      chk("halted",      vidx, 32'(bus.halted),      32'(e.e_halt));
      chk("fsm_err",     vidx, 32'(bus.fsm_err),     32'(e.e_err));
      chk("instr_count", vidx, 32'(bus.instr_count), 32'(e.e_cnt));
      vidx++;
    end
  end

  task automatic build_table();
    ecnt = '0;
    // reg-reg ALU
    add(16'h0000, 5'h00, 0, 1, E1, 0, 0, 0);  add(16'h0000, 5'h00, 0, 1, E2, 0, 0, 0);
    add(16'h0000, 5'h00, 0, 1, E3, 0, 0, 0);  add(16'h0000, 5'h00, 0, 1, E12, 0, 0, 0);
    add(16'h0000, 5'h00, 0, 1, E0, 0, 0, 1);
    // ALU immediate
    add(16'h4000, 5'h00, 0, 1, E1, 0, 0, 0);  add(16'h4000, 5'h00, 0, 1, E2, 0, 0, 0);
    add(16'h4000, 5'h00, 0, 1, E4, 0, 0, 0);  add(16'h4000, 5'h00, 0, 1, E12, 0, 0, 0);
    add(16'h4000, 5'h00, 0, 1, E0, 0, 0, 1);
    // load: fetch stall, then S5 held four cycles
    add(16'h8000, 5'h00, 0, 0, E0, 0, 0, 0);  add(16'h8000, 5'h00, 0, 1, E1, 0, 0, 0);
    add(16'h8000, 5'h00, 0, 1, E2, 0, 0, 0);  add(16'h8000, 5'h00, 0, 1, E5, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(16'h8000, 5'h00, 0, 0, E5, 0, 0, 0);
    add(16'h8000, 5'h00, 0, 1, E9, 0, 0, 0);  add(16'h8000, 5'h00, 0, 1, E12, 0, 0, 0);
    add(16'h8000, 5'h00, 0, 1, E0, 0, 0, 1);
    // store skips writeback
    add(16'h8800, 5'h00, 0, 1, E1, 0, 0, 0);  add(16'h8800, 5'h00, 0, 1, E2, 0, 0, 0);
    add(16'h8800, 5'h00, 0, 1, E5, 0, 0, 0);  add(16'h8800, 5'h00, 0, 1, E12, 0, 0, 0);
    add(16'h8800, 5'h00, 0, 1, E0, 0, 0, 1);
    // branch
    add(16'hC000, 5'h00, 0, 1, E1, 0, 0, 0);  add(16'hC000, 5'h00, 0, 1, E2, 0, 0, 0);
    add(16'hC000, 5'h00, 0, 1, E6, 0, 0, 0);  add(16'hC000, 5'h00, 0, 1, E7, 0, 0, 0);
    add(16'hC000, 5'h00, 0, 1, E12, 0, 0, 0); add(16'hC000, 5'h00, 0, 1, E0, 0, 0, 1);
    // call
    add(16'hD000, 5'h00, 0, 1, E1, 0, 0, 0);  add(16'hD000, 5'h00, 0, 1, E2, 0, 0, 0);
    add(16'hD000, 5'h00, 0, 1, E8, 0, 0, 0);  add(16'hD000, 5'h00, 0, 1, E9, 0, 0, 0);
    add(16'hD000, 5'h00, 0, 1, E12, 0, 0, 0); add(16'hD000, 5'h00, 0, 1, E0, 0, 0, 1);
    // return
    add(16'hE000, 5'h00, 0, 1, E1, 0, 0, 0);  add(16'hE000, 5'h00, 0, 1, E2, 0, 0, 0);
    add(16'hE000, 5'h00, 0, 1, E10, 0, 0, 0); add(16'hE000, 5'h00, 0, 1, E12, 0, 0, 0);
    add(16'hE000, 5'h00, 0, 1, E0, 0, 0, 1);
    // software trap with irq pending: no retire, no ack, no second trap
    add(16'hF000, 5'h10, 1, 1, E1, 0, 0, 0);  add(16'hF000, 5'h10, 1, 1, E2, 0, 0, 0);
    add(16'hF000, 5'h10, 1, 1, E11, 0, 0, 0); add(16'hF000, 5'h10, 1, 1, E0, 0, 0, 0);
    // enabled irq taken at retire
    add(16'h0000, 5'h10, 1, 1, E1, 0, 0, 0);  add(16'h0000, 5'h10, 1, 1, E2, 0, 0, 0);
    add(16'h0000, 5'h10, 1, 1, E3, 0, 0, 0);  add(16'h0000, 5'h10, 1, 1, E12, 0, 0, 0);
    add(16'h0000, 5'h10, 1, 1, E11, 1, 0, 1); add(16'h0000, 5'h10, 1, 1, E0, 0, 0, 0);
    // irq masked
    add(16'h0000, 5'h00, 1, 1, E1, 0, 0, 0);  add(16'h0000, 5'h00, 1, 1, E2, 0, 0, 0);
    add(16'h0000, 5'h00, 1, 1, E3, 0, 0, 0);  add(16'h0000, 5'h00, 1, 1, E12, 0, 0, 0);
    add(16'h0000, 5'h00, 1, 1, E0, 0, 0, 1);
    // mem_ready and irq together in S5: load completes, trap at retire
    add(16'h8000, 5'h10, 1, 1, E1, 0, 0, 0);  add(16'h8000, 5'h10, 1, 1, E2, 0, 0, 0);
    add(16'h8000, 5'h10, 1, 1, E5, 0, 0, 0);  add(16'h8000, 5'h10, 1, 1, E9, 0, 0, 0);
    add(16'h8000, 5'h10, 1, 1, E12, 0, 0, 0); add(16'h8000, 5'h10, 1, 1, E11, 1, 0, 1);
    add(16'h8000, 5'h10, 1, 1, E0, 0, 0, 0);
    // halt: park 20 cycles, ignore masked irq, leave on enabled irq
    add(16'hFFFF, 5'h00, 0, 1, E1, 0, 0, 0);  add(16'hFFFF, 5'h00, 0, 1, E2, 0, 0, 0);
    for (int i = 0; i < 20; i++) add(16'hFFFF, 5'h00, 0, 1, E2, 0, 1, 0);
    for (int i = 0; i < 3; i++)  add(16'hFFFF, 5'h00, 1, 1, E2, 0, 1, 0);
    add(16'hFFFF, 5'h10, 1, 1, E11, 1, 0, 0); add(16'hFFFF, 5'h00, 0, 1, E0, 0, 0, 0);
    // counter wraps from 10 to 0 after six more retires
    for (int i = 0; i < 6; i++) begin
      add(16'h0000, 5'h00, 0, 1, E1, 0, 0, 0);  add(16'h0000, 5'h00, 0, 1, E2, 0, 0, 0);
      add(16'h0000, 5'h00, 0, 1, E3, 0, 0, 0);  add(16'h0000, 5'h00, 0, 1, E12, 0, 0, 0);
      add(16'h0000, 5'h00, 0, 1, E0, 0, 0, 1);
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
    chk("scoreboard_empty", vidx, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vec_t v;
    rst_n         = 1'b0;
    bus.ir        = 16'h0000;
    bus.status    = 5'h00;
    bus.irq       = 1'b0;
    bus.mem_ready = 1'b0;
    build_table();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state",   -1, 32'(bus.state),       32'(E0));
    chk("reset_irq_ack", -1, 32'(bus.irq_ack),     32'd0);
    chk("reset_halted",  -1, 32'(bus.halted),      32'd0);
    chk("reset_fsm_err", -1, 32'(bus.fsm_err),     32'd0);
    chk("reset_count",   -1, 32'(bus.instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);
    drain();

    // Corrupt the state register to a two-hot value just before an edge.
    @(negedge clk);
    drive(mk(16'h0000, 1'b1, E0, 1'b1, ecnt));
    force dut.state_q = 13'h0005;
    #1;
    release dut.state_q;
    sb.push_back(mk(16'h0000, 1'b1, E0, 1'b1, ecnt));
    apply(mk(16'h8000, 1'b1, E1, 1'b1, ecnt));
    apply(mk(16'h8000, 1'b1, E2, 1'b1, ecnt));
    apply(mk(16'h8000, 1'b1, E5, 1'b1, ecnt));
    apply(mk(16'h8000, 1'b0, E5, 1'b1, ecnt));
    drain();

    // Asynchronous reset in the middle of a stalled memory access.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_state",   -2, 32'(bus.state),       32'(E0));
    chk("midreset_fsm_err", -2, 32'(bus.fsm_err),     32'd0);
    chk("midreset_count",   -2, 32'(bus.instr_count), 32'd0);
    chk("midreset_halted",  -2, 32'(bus.halted),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(16'h0000, 1'b1, E1,  1'b0, 4'd0));
    apply(mk(16'h0000, 1'b1, E2,  1'b0, 4'd0));
    apply(mk(16'h0000, 1'b1, E3,  1'b0, 4'd0));
    apply(mk(16'h0000, 1'b1, E12, 1'b0, 4'd0));
    v = mk(16'h0000, 1'b1, E0, 1'b0, 4'd1);
    apply(v);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- One-hot state generator for the mARC control unit; drives the 13-bit `state` vector that the control-word output logic decodes into datapath control.
- Sequences fetch, decode, execute and writeback per instruction. Stalls on memory, dispatches on IR fields, services interrupts at instruction boundaries, and detects illegal (non-one-hot) states.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- HALT_OPCODE, 16'hFFFF, IR value that halts the sequencer in DECODE

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ir  in  16  instruction register contents
- status  in  5  PSR flags; status[4] = interrupt enable
- mem_ready  in  1  main memory access complete this cycle
- irq  in  1  level-sensitive interrupt request
- state  out  13  one-hot current state, bit n = Sn
- irq_ack  out  1  one-cycle pulse on interrupt acceptance
- halted  out  1  sequencer parked on HALT_OPCODE
- fsm_err  out  1  sticky; set when a non-one-hot state is detected
- instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset is asynchronous and active-low, one clock domain (clk, rst_n).
- Reset values: state=13'h0001 (S0), irq_ack=0, halted=0, fsm_err=0, instr_count=0.
- Reset mid-instruction aborts immediately to S0. No partial retire is counted.
- Exactly one transition per clock. All outputs are registered.
- Transitions:
  - S0 FETCH: stay while !mem_ready; else S1.
  - S1 LOAD_IR: go to S2.
  - S2 DECODE: if ir==HALT_OPCODE, stay in S2 with halted=1. Otherwise dispatch on ir[15:14]:
    - 00: S3 (ALU reg-reg)
    - 01: S4 (ALU immediate)
    - 10: S5 (memory)
    - 11, by ir[13:12]: 00 -> S6 (branch eval), 01 -> S8 (call link), 10 -> S10 (return), 11 -> S11 (software trap)
  - S3, S4: go to S12.
  - S5 MEM: stay while !mem_ready. When mem_ready: ir[11]=0 (load) -> S9; ir[11]=1 (store) -> S12.
  - S6: go to S7. S7 BR_UPDATE: go to S12.
  - S8: go to S9. S9 WRITEBACK: go to S12. S10: go to S12.
  - S11 TRAP_ENTRY: go to S0.
  - S12 RETIRE: instr_count += 1 (wraps modulo 2^CNT_W). Then irq & status[4] -> S11 with irq_ack=1 for that transition cycle; else -> S0.
- Halted: while in S2 halted, irq & status[4] -> S11, irq_ack pulse, halted cleared. A halt is not counted as retired. Without an enabled irq, halt persists indefinitely.
- Interrupts are sampled only in S12 and halted-S2. An irq asserted elsewhere is held by the source, not latched here.
- S11 is always followed by S0, never by a second trap, even if irq is still high.
- Software trap path: S2 -> S11 -> S0 retires nothing.
- Illegal state: if popcount(state) != 1, next state = S0 and fsm_err <= 1. fsm_err clears only on reset.
- mem_ready is ignored outside S0/S5.
- Simultaneous mem_ready and irq in S5: memory completes first; the interrupt is taken at the following S12.

Decomposition:
- Shared package `marc_ctrl_pkg`:
  - state index constants S_FETCH=0 … S_RETIRE=12
  - STATE_W=13, STATE_RESET=13'h0001
  - opclass constants for ir[15:14] and control sub-class ir[13:12]
- The output-logic block also imports these so that state bit numbering has a single source of truth.
- No sub-module. Next-state logic, retire counter and one-hot check live in one module.

Test Plan:
- Reg-reg ALU: reset, ir=16'h0000, mem_ready=1 -> state sequence 0x0001, 0x0002, 0x0004, 0x0008, 0x1000, 0x0001; instr_count=1.
- Load with stall: ir=16'h8000, mem_ready low 3 cycles in S5 -> S5 held 4 cycles, then S9, S12, S0; store ir=16'h8800 skips S9.
- Interrupt: irq=1, status=5'h10 during S12 -> irq_ack=1 for one cycle, next S11 then S0. With status=5'h00 -> straight to S0, irq_ack=0.
- Halt: ir=16'hFFFF -> parks in S2, halted=1, count unchanged for 20 cycles. Enabled irq -> S11, halted=0.
- Corruption: force state=13'h0005 -> next cycle S0, fsm_err=1 sticky. rst_n low mid-S5 -> immediately S0, fsm_err=0.
- Counter wrap: CNT_W=4, 16 retires -> instr_count returns to 0.
